// File: rtl/riscv_m_pkg.sv
// ---------------------------------------------------------------------------
// riscv_m_pkg
// Shared types and constants for the RV32M/RV64M multiply/divide unit.
//   muldiv_op_e    : operation code; values equal the funct3 encodings.
//   muldiv_state_e : iterative unit control states.
//   FUNCT7_MULDIV  : funct7 value that routes an R-type to this unit.
// ---------------------------------------------------------------------------
package riscv_m_pkg;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } muldiv_state_e;

endpackage : riscv_m_pkg

// File: rtl/muldiv_unit_if.sv
// ---------------------------------------------------------------------------
// muldiv_unit_if
// Request/response bundle between the issuing pipeline (master) and the
// multiply/divide unit (slave).
//   start, kill, funct3, a, b : master -> unit
//   busy, done, result        : unit -> master
//   dbg_state                 : unit -> master, current control state
//
// Handshake: the master raises start with funct3/a/b valid for one cycle.
// The request is taken at a rising edge only when the unit is idle (busy low)
// and kill is low; operands need not be held afterwards. While busy is high
// further starts are dropped. Completion is a single-cycle done pulse during
// which result is valid; result then holds until the next done. kill drops an
// in-flight request before its done pulse and never produces one.
// ---------------------------------------------------------------------------
interface muldiv_unit_if
    import riscv_m_pkg::*;
#(
    parameter int XLEN = 32
);
    logic            start;
    logic            kill;
    logic [2:0]      funct3;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    muldiv_state_e   dbg_state;

    modport master (
        output start, kill, funct3, a, b,
        input  busy, done, result, dbg_state
    );

    modport slave (
        input  start, kill, funct3, a, b,
        output busy, done, result, dbg_state
    );

endinterface : muldiv_unit_if

// File: rtl/muldiv_decode.sv
// ---------------------------------------------------------------------------
// muldiv_decode
// Combinational funct3 decoder for the multiply/divide unit.
//   funct3   in  : operation code
//   is_div   out : divide family (DIV/DIVU/REM/REMU)
//   is_rem   out : remainder result wanted
//   a_signed out : rs1 treated as two's complement
//   b_signed out : rs2 treated as two's complement
//   sel_high out : multiply returns the upper product half
// ---------------------------------------------------------------------------
module muldiv_decode
    import riscv_m_pkg::*;
(
    input  logic [2:0] funct3,
    output logic       is_div,
    output logic       is_rem,
    output logic       a_signed,
    output logic       b_signed,
    output logic       sel_high
);

    muldiv_op_e op;
    assign op = muldiv_op_e'(funct3);

    always_comb begin
        is_div   = 1'b0;
        is_rem   = 1'b0;
        a_signed = 1'b0;
        b_signed = 1'b0;
        sel_high = 1'b0;
        case (op)
            OP_MUL: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            OP_MULH: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
                sel_high = 1'b1;
            end
            OP_MULHSU: begin
                a_signed = 1'b1;
                sel_high = 1'b1;
            end
            OP_MULHU: begin
                sel_high = 1'b1;
            end
            OP_DIV: begin
                is_div   = 1'b1;
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            OP_DIVU: begin
                is_div   = 1'b1;
            end
            OP_REM: begin
                is_div   = 1'b1;
                is_rem   = 1'b1;
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            OP_REMU: begin
                is_div   = 1'b1;
                is_rem   = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule : muldiv_decode

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
// Iterative RV32M/RV64M multiply/divide unit. Operands are converted to
// magnitudes at capture, XLEN shift-add (multiply) or restoring
// shift-subtract (divide) steps run on a 2*XLEN accumulator, and a final
// cycle applies sign correction and picks the result half.
//   clk    in  : clock, rising edge
//   reset  in  : synchronous active-high reset
//   bus    slave modport of muldiv_unit_if:
//     start/kill/funct3/a/b in, busy/done/result/dbg_state out
// Divide-by-zero and signed overflow are resolved at capture and skip
// straight to DONE.
// ---------------------------------------------------------------------------
module muldiv_unit
    import riscv_m_pkg::*;
#(
    parameter int XLEN = 32
)(
    input  logic          clk,
    input  logic          reset,
    muldiv_unit_if.slave  bus
);

    localparam int CW = $clog2(XLEN);

    // ------------------------------------------------------------------
    // Decode of the live request (only consumed on the capture edge)
    // ------------------------------------------------------------------
    logic dec_is_div;
    logic dec_is_rem;
    logic dec_a_signed;
    logic dec_b_signed;
    logic dec_sel_high;

    muldiv_decode u_decode (
        .funct3   (bus.funct3),
        .is_div   (dec_is_div),
        .is_rem   (dec_is_rem),
        .a_signed (dec_a_signed),
        .b_signed (dec_b_signed),
        .sel_high (dec_sel_high)
    );

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    muldiv_state_e     state;
    muldiv_state_e     state_next;
    logic [CW-1:0]     counter;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   operand;     // multiplicand (mul) or divisor (div)
    logic              op_is_div;
    logic              op_is_rem;
    logic              op_sel_high;
    logic              neg_q;       // negate product / quotient
    logic              neg_r;       // negate remainder
    logic [XLEN-1:0]   result_q;

    // ------------------------------------------------------------------
    // Capture-time operand conditioning and special-case detection
    // ------------------------------------------------------------------
    logic            accept;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            div_by_zero;
    logic            div_overflow;
    logic            special;
    logic [XLEN-1:0] special_result;

    assign accept = (state == IDLE) && bus.start && !bus.kill;

    always_comb begin
        a_neg = dec_a_signed && bus.a[XLEN-1];
        b_neg = dec_b_signed && bus.b[XLEN-1];
        // The most-negative value negates to itself, which is also its
        // correct unsigned magnitude.
        a_mag = a_neg ? -bus.a : bus.a;
        b_mag = b_neg ? -bus.b : bus.b;

        div_by_zero  = dec_is_div && (bus.b == '0);
        div_overflow = dec_is_div && dec_a_signed
                       && (bus.a == {1'b1, {(XLEN-1){1'b0}}})
                       && (bus.b == '1);
        special = div_by_zero || div_overflow;

        if (div_by_zero) begin
            special_result = dec_is_rem ? bus.a : '1;
        end else begin
            special_result = dec_is_rem ? '0 : bus.a;
        end
    end

    // ------------------------------------------------------------------
    // One iteration step
    // Multiply: acc = {partial_high, remaining multiplier bits}; add the
    //   multiplicand when the current LSB is set, then shift right with the
    //   carry entering at the top.
    // Divide: acc = {partial_remainder, dividend/quotient bits}; shift left,
    //   trial-subtract the divisor and shift in the quotient bit.
    // ------------------------------------------------------------------
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] acc_step;

    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
        div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_diff  = div_shift - {1'b0, operand};
        if (op_is_div) begin
            // A borrow out of the trial subtraction means "restore".
            if (!div_diff[XLEN]) begin
                acc_step = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            end else begin
                acc_step = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_step = {mul_sum, acc[XLEN-1:1]};
        end
    end

    // ------------------------------------------------------------------
    // Sign correction and result selection
    // ------------------------------------------------------------------
    logic [2*XLEN-1:0] prod_signed;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   fixed_result;

    always_comb begin
        prod_signed = neg_q ? -acc : acc;
        quo = acc[XLEN-1:0];
        rem = acc[2*XLEN-1:XLEN];
        if (!op_is_div) begin
            fixed_result = op_sel_high ? prod_signed[2*XLEN-1:XLEN]
                                       : prod_signed[XLEN-1:0];
        end else if (op_is_rem) begin
            fixed_result = neg_r ? -rem : rem;
        end else begin
            fixed_result = neg_q ? -quo : quo;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = special ? DONE : CALC;
                end
            end
            CALC: begin
                if (bus.kill) begin
                    state_next = IDLE;
                end else if (counter == '0) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                state_next = bus.kill ? IDLE : DONE;
            end
            DONE: begin
                // kill here is too late; the pulse is already out.
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            counter     <= '0;
            acc         <= '0;
            operand     <= '0;
            op_is_div   <= 1'b0;
            op_is_rem   <= 1'b0;
            op_sel_high <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            result_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_is_div   <= dec_is_div;
                        op_is_rem   <= dec_is_rem;
                        op_sel_high <= dec_sel_high;
                        // Signedness is already folded into a_neg/b_neg, so
                        // one expression covers product and quotient.
                        neg_q       <= a_neg ^ b_neg;
                        neg_r       <= a_neg;
                        counter     <= CW'(XLEN-1);
                        if (dec_is_div) begin
                            acc     <= {{XLEN{1'b0}}, a_mag};
                            operand <= b_mag;
                        end else begin
                            acc     <= {{XLEN{1'b0}}, b_mag};
                            operand <= a_mag;
                        end
                        if (special) begin
                            result_q <= special_result;
                        end
                    end
                end
                CALC: begin
                    if (!bus.kill) begin
                        acc <= acc_step;
                        if (counter != '0) begin
                            counter <= counter - 1'b1;
                        end
                    end
                end
                FIX: begin
                    if (!bus.kill) begin
                        result_q <= fixed_result;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs (all derived from registers)
    // ------------------------------------------------------------------
    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);
    assign bus.result    = result_q;
    assign bus.dbg_state = state;

endmodule : muldiv_unit

// File: tb/tb_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_unit
// Directed and randomized bench for muldiv_unit at XLEN = 32. Expected
// results come from plain 64-bit arithmetic on the RISC-V M-extension rules.
// ---------------------------------------------------------------------------
module tb_muldiv_unit;
    import riscv_m_pkg::*;

    localparam int XLEN = 32;
    localparam int NORMAL_LAT = XLEN + 1;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;
    logic [XLEN-1:0] exp_q[$];

    muldiv_unit_if #(.XLEN(XLEN)) bus ();

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [XLEN-1:0] ref_model(input logic [2:0] f,
                                                  input logic [XLEN-1:0] a,
                                                  input logic [XLEN-1:0] b);
        longint    sa;
        longint    sb;
        longint    ua;
        longint    ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        case (f)
            3'b000: begin p = sa * sb; return p[31:0];  end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * ub; return p[63:32]; end
            3'b011: begin p = ua * ub; return p[63:32]; end
            3'b100: begin
                if (b == 0) return '1;
                p = sa / sb; return p[31:0];
            end
            3'b101: begin
                if (b == 0) return '1;
                p = ua / ub; return p[31:0];
            end
            3'b110: begin
                if (b == 0) return a;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    // Presents a request on the falling edge; returns just after edge 0.
    task automatic issue(input logic [2:0] f, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.funct3 = f;
        bus.a      = a;
        bus.b      = b;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
    endtask

    // Returns the number of edges after the current one at which done was
    // first seen (0 = already high), or -1 if the budget ran out.
    task automatic wait_done(output int lat, output logic [XLEN-1:0] res);
        lat = -1;
        res = '0;
        for (int k = 0; k < 80; k++) begin
            if (bus.done) begin
                lat = k;
                res = bus.result;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.kill  = 1'b0;
        bus.funct3 = 3'b000;
        bus.a     = '0;
        bus.b     = '0;
        step(3);
        reset = 1'b0;
        vectors++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== '0
            || bus.dbg_state !== IDLE) begin
            miscompares++;
            $display("FAIL reset: busy=%b done=%b result=%h state=%0d, want 0 0 0 IDLE",
                     bus.busy, bus.done, bus.result, bus.dbg_state);
        end
    endtask

    task automatic test_mul_latency();
        int lat;
        logic [XLEN-1:0] res;
        issue(3'b000, 32'd7, 32'hFFFF_FFFD);
        vectors++;
        if (bus.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL mul_busy: busy=%b want 1", bus.busy);
        end
        wait_done(lat, res);
        vectors++;
        if (lat !== NORMAL_LAT) begin
            miscompares++;
            $display("FAIL mul_latency: got %0d want %0d", lat, NORMAL_LAT);
        end
        vectors++;
        if (res !== 32'hFFFF_FFEB) begin
            miscompares++;
            $display("FAIL mul_result: got %h want ffffffeb", res);
        end
        step(1);
        vectors++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL mul_after: busy=%b done=%b want 0 0", bus.busy, bus.done);
        end
    endtask

    task automatic test_directed();
        logic [2:0]      f_t[12]   = '{3'b011, 3'b001, 3'b010, 3'b100, 3'b110, 3'b101,
                                       3'b111, 3'b101, 3'b111, 3'b100, 3'b110, 3'b000};
        logic [XLEN-1:0] a_t[12]   = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                       32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                                       32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'd3};
        logic [XLEN-1:0] b_t[12]   = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd2,
                                       32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF,
                                       32'hFFFF_FFFF, 32'd4};
        logic [XLEN-1:0] r_t[12]   = '{32'hFFFF_FFFE, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
                                       32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5,
                                       32'h8000_0000, 32'd0, 32'd12};
        int              lat_t[12] = '{33, 33, 33, 33, 33, 33, 33, 0, 0, 0, 0, 33};
        int lat;
        logic [XLEN-1:0] res;
        for (int i = 0; i < 12; i++) begin
            issue(f_t[i], a_t[i], b_t[i]);
            wait_done(lat, res);
            vectors++;
            if (lat !== lat_t[i] || res !== r_t[i]) begin
                miscompares++;
                $display("FAIL directed[%0d] f=%b: result=%h lat=%0d want %h lat=%0d",
                         i, f_t[i], res, lat, r_t[i], lat_t[i]);
            end
            step(1);
        end
    endtask

    task automatic test_kill();
        int lat;
        logic [XLEN-1:0] res;
        logic [XLEN-1:0] prior;
        bit seen_done;
        prior = bus.result;
        issue(3'b100, 32'd1000, 32'd3);
        step(9);
        @(negedge clk);
        bus.kill = 1'b1;
        @(posedge clk);
        #1;
        bus.kill = 1'b0;
        vectors++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== prior) begin
            miscompares++;
            $display("FAIL kill: busy=%b done=%b result=%h want 0 0 %h",
                     bus.busy, bus.done, bus.result, prior);
        end
        issue(3'b000, 32'd3, 32'd4);
        wait_done(lat, res);
        vectors++;
        if (res !== 32'd12 || lat !== NORMAL_LAT) begin
            miscompares++;
            $display("FAIL kill_next: result=%h lat=%0d want 0000000c lat=%0d",
                     res, lat, NORMAL_LAT);
        end
        step(1);
        // start and kill together in IDLE: not accepted.
        prior = bus.result;
        @(negedge clk);
        bus.start = 1'b1; bus.kill = 1'b1;
        bus.funct3 = 3'b101; bus.a = 32'd9; bus.b = 32'd0;
        @(posedge clk);
        #1;
        bus.start = 1'b0; bus.kill = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done || bus.busy) seen_done = 1'b1;
            step(1);
        end
        vectors++;
        if (seen_done !== 1'b0 || bus.result !== prior) begin
            miscompares++;
            $display("FAIL start_kill_idle: activity=%b result=%h want 0 %h",
                     seen_done, bus.result, prior);
        end
    endtask

    task automatic test_start_ignored();
        int lat;
        logic [XLEN-1:0] res;
        issue(3'b101, 32'd1000, 32'd7);
        step(4);
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = 3'b000; bus.a = 32'd5; bus.b = 32'd5;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(lat, res);
        vectors++;
        if (res !== 32'd142 || lat + 5 !== NORMAL_LAT) begin
            miscompares++;
            $display("FAIL start_while_busy: result=%h lat=%0d want 0000008e lat=%0d",
                     res, lat + 5, NORMAL_LAT);
        end
        step(1);
    endtask

    task automatic test_reset_mid();
        bit seen_done;
        issue(3'b000, 32'd11, 32'd13);
        step(19);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        vectors++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== '0) begin
            miscompares++;
            $display("FAIL reset_mid: busy=%b done=%b result=%h want 0 0 0",
                     bus.busy, bus.done, bus.result);
        end
        seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done) seen_done = 1'b1;
            step(1);
        end
        vectors++;
        if (seen_done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_done: done seen=%b want 0", seen_done);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [XLEN-1:0] res;
        issue(3'b110, 32'd100, 32'hFFFF_FFF9);    // 100 rem -7 = 2
        wait_done(lat, res);
        vectors++;
        if (res !== 32'd2) begin
            miscompares++;
            $display("FAIL b2b_first: got %h want 00000002", res);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_idle: busy=%b want 0", bus.busy);
        end
        issue(3'b001, 32'h8000_0000, 32'h8000_0000);   // MULH MIN*MIN = 2^62
        wait_done(lat, res);
        vectors++;
        if (res !== 32'h4000_0000 || lat !== NORMAL_LAT) begin
            miscompares++;
            $display("FAIL b2b_second: got %h lat=%0d want 40000000 lat=%0d",
                     res, lat, NORMAL_LAT);
        end
        step(1);
    endtask

    function automatic logic [XLEN-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return 32'h8000_0000;
            2:       return '1;
            3:       return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    task automatic test_random();
        int lat;
        logic [XLEN-1:0] res;
        logic [XLEN-1:0] exp;
        logic [2:0]      f;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom_range(0, 7));
            a = pick_operand();
            b = pick_operand();
            exp_q.push_back(ref_model(f, a, b));
            issue(f, a, b);
            wait_done(lat, res);
            exp = exp_q.pop_front();
            vectors++;
            if (res !== exp || lat < 0) begin
                miscompares++;
                $display("FAIL random[%0d] f=%b a=%h b=%h: got %h lat=%0d want %h",
                         i, f, a, b, res, lat, exp);
            end
            step(1);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_mul_latency();
        test_directed();
        test_kill();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_muldiv_unit
